// File: rtl/disk_ctrl.sv
// ---------------------------------------------------------------------------
// disk_ctrl
//   Device-side disk controller. Holds a 128 x 32-bit block buffer that the
//   CPU accesses word by word, and moves whole blocks between that buffer and
//   a word-addressed backing store when the adapter pulses write_pause /
//   read_pause. Completion is flagged by a single-cycle disk_operate_done.
//
// Ports
//   clk, rst           clock, asynchronous active-low reset
//   instruction        [31] select, [30] we, [29] 1=disk/0=buffer,
//                      [BLK_W-1:0] block number used for transfers
//   write_pause        pulse: buffer -> backing-store block
//   read_pause         pulse: backing-store block -> buffer
//   disk_addr          buffer byte address (word index = [8:2])
//   buf_wdata          CPU write data into the buffer
//   buf_rdata          registered buffer read data (1-cycle latency)
//   disk_operate_done  one-cycle completion pulse
//   busy               block transfer in progress (XFER or DONE)
//   mem_req/mem_we/mem_addr/mem_wdata   backing-store request
//   mem_rdata/mem_ack  backing-store response; ack may coincide with req
// ---------------------------------------------------------------------------
module disk_ctrl #(
  parameter int unsigned BLK_W  = 16,
  parameter int unsigned MEM_AW = BLK_W + 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instruction,
  input  logic              write_pause,
  input  logic              read_pause,
  input  logic [8:0]        disk_addr,
  input  logic [31:0]       buf_wdata,
  output logic [31:0]       buf_rdata,
  output logic              disk_operate_done,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q;
  logic [6:0]        word_q;
  logic [6:0]        word_d;
  logic [BLK_W-1:0]  block_q;
  logic [31:0]       buf_rdata_q;
  logic              done_q;
  logic              busy_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [MEM_AW-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;

  // Block buffer; contents deliberately survive reset.
  logic [31:0] buf_mem [128];

  logic [6:0] cpu_idx;
  logic       cpu_wr;
  logic       xfer_ack;
  logic       xfer_rd_wr;
  logic       unused_ok;

  assign cpu_idx = disk_addr[8:2];
  // CPU buffer writes are only honoured in IDLE so a transfer sees a stable buffer.
  assign cpu_wr     = instruction[31] & instruction[30] & ~instruction[29] & (state_q == IDLE);
  // Ack counts only while a request is outstanding, i.e. in XFER.
  assign xfer_ack   = (state_q == XFER) & mem_ack;
  assign xfer_rd_wr = xfer_ack & ~mem_we_q;
  assign word_d     = word_q + 7'd1;

  assign unused_ok = ^{instruction, disk_addr[1:0]};

  // Buffer write port: CPU in IDLE, backing-store read data in XFER.
  // The two sources are exclusive by state.
  always_ff @(posedge clk) begin
    if (cpu_wr) begin
      buf_mem[cpu_idx] <= buf_wdata;
    end else if (xfer_rd_wr) begin
      buf_mem[word_q] <= mem_rdata;
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      word_q      <= '0;
      block_q     <= '0;
      buf_rdata_q <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      buf_rdata_q <= buf_mem[cpu_idx];
      done_q      <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (write_pause || read_pause) begin
            // write_pause has priority when both arrive together.
            block_q    <= instruction[BLK_W-1:0];
            mem_we_q   <= write_pause;
            word_q     <= '0;
            mem_req_q  <= 1'b1;
            busy_q     <= 1'b1;
            mem_addr_q <= MEM_AW'({instruction[BLK_W-1:0], 7'd0});
            if (write_pause) begin
              mem_wdata_q <= buf_mem[0];
            end
            state_q <= XFER;
          end
        end
        XFER: begin
          if (mem_ack) begin
            if (word_q == 7'd127) begin
              // Last word: counter holds at 127 rather than wrapping.
              mem_req_q <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= DONE;
            end else begin
              // Present the next word immediately so back-to-back acks
              // give one word per cycle.
              word_q     <= word_d;
              mem_addr_q <= MEM_AW'({block_q, word_d});
              if (mem_we_q) begin
                mem_wdata_q <= buf_mem[word_d];
              end
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign buf_rdata         = buf_rdata_q;
  assign disk_operate_done = done_q;
  assign busy              = busy_q;
  assign mem_req           = mem_req_q;
  assign mem_we            = mem_we_q;
  assign mem_addr          = mem_addr_q;
  assign mem_wdata         = mem_wdata_q;

endmodule
